// File: rtl/cu_fsm_mc_pkg.sv
// Shared types for the OTTER multicycle control unit.
// Contents: RV32I major opcodes, the control FSM states and the SYSTEM func3 codes.
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH      = 3'd0,
        EXECUTE    = 3'd1,
        MEM_WAIT   = 3'd2,
        WRITE_BACK = 3'd3,
        INTERRUPT  = 3'd4
    } cu_state_t;

    localparam logic [2:0] F3_PRIV  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;

    function automatic logic is_csr_f3(input logic [2:0] f3);
        return (f3 == F3_CSRRW) || (f3 == F3_CSRRS) || (f3 == F3_CSRRC);
    endfunction

endpackage

// File: rtl/cu_fsm_mc_if.sv
// Instruction/handshake inputs and strobe outputs of the control unit.
// The slave modport is the control unit; the master modport is the core datapath side.
interface cu_fsm_mc_if #(
    parameter int NUM_IRQ = 4
);
    localparam int IRQ_W = $clog2(NUM_IRQ);

    logic [31:0]        DIN;
    logic               IMEM_RDY;
    logic               DMEM_RDY;
    logic [NUM_IRQ-1:0] IRQ;
    logic [NUM_IRQ-1:0] IRQ_MASK;
    logic               MIE;

    logic               PC_WRITE;
    logic               REG_WRITE;
    logic               MEM_WRITE;
    logic               MEM_READ1;
    logic               MEM_READ2;
    logic               CSR_WRITE;
    logic               INT_TAKEN;
    logic               ILLEGAL;
    logic [IRQ_W-1:0]   INT_CAUSE;
    logic               INT_EXC;

    modport slave (
        input  DIN, IMEM_RDY, DMEM_RDY, IRQ, IRQ_MASK, MIE,
        output PC_WRITE, REG_WRITE, MEM_WRITE, MEM_READ1, MEM_READ2,
               CSR_WRITE, INT_TAKEN, ILLEGAL, INT_CAUSE, INT_EXC
    );

    modport master (
        output DIN, IMEM_RDY, DMEM_RDY, IRQ, IRQ_MASK, MIE,
        input  PC_WRITE, REG_WRITE, MEM_WRITE, MEM_READ1, MEM_READ2,
               CSR_WRITE, INT_TAKEN, ILLEGAL, INT_CAUSE, INT_EXC
    );

endinterface

// File: rtl/cu_fsm_mc_irq_prio_enc.sv
// Fixed-priority encoder for pending interrupt lines; the lowest set index wins.
module irq_prio_enc #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] pending,
    output logic         valid,
    output logic [W-1:0] idx
);

    always_comb begin
        valid = |pending;
        idx   = '0;
        // Scan downward so the lowest pending index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) idx = i[W-1:0];
        end
    end

endmodule

// File: rtl/cu_fsm_mc.sv
// OTTER RV32I multicycle control FSM with memory wait states, prioritised
// maskable interrupts and illegal-opcode trapping.
module cu_fsm_mc
    import otter_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic         CLK,
    input  logic         RST,
    cu_fsm_mc_if.slave   bus
);

    localparam int IRQ_W = $clog2(NUM_IRQ);

    cu_state_t          ps;
    cu_state_t          ns;
    logic [6:0]         opcode;
    logic [2:0]         func3;
    logic [NUM_IRQ-1:0] pending;
    logic               pend_valid;
    logic [IRQ_W-1:0]   pend_idx;
    logic               boundary;
    logic               take_irq;
    logic               take_exc;
    logic [IRQ_W-1:0]   int_cause_q;
    logic               int_exc_q;

    logic pc_write, reg_write, mem_write, mem_read1, mem_read2;
    logic csr_write, int_taken, illegal;

    assign opcode  = bus.DIN[6:0];
    assign func3   = bus.DIN[14:12];
    assign pending = bus.IRQ & bus.IRQ_MASK & {NUM_IRQ{bus.MIE}};

    irq_prio_enc #(.N(NUM_IRQ)) u_prio (
        .pending (pending),
        .valid   (pend_valid),
        .idx     (pend_idx)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ps          <= FETCH;
            int_cause_q <= '0;
            int_exc_q   <= 1'b0;
        end else begin
            ps <= ns;
            if (take_exc) begin
                int_cause_q <= '0;
                int_exc_q   <= 1'b1;
            end else if (take_irq) begin
                int_cause_q <= pend_idx;
                int_exc_q   <= 1'b0;
            end
        end
    end

    always_comb begin
        ns        = FETCH;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        mem_read1 = 1'b0;
        mem_read2 = 1'b0;
        csr_write = 1'b0;
        int_taken = 1'b0;
        illegal   = 1'b0;
        boundary  = 1'b0;
        take_irq  = 1'b0;
        take_exc  = 1'b0;

        // Strobes are forced low for the whole time reset is held.
        if (!RST) begin
            case (ps)
                FETCH: begin
                    mem_read1 = 1'b1;
                    ns        = bus.IMEM_RDY ? EXECUTE : FETCH;
                end

                EXECUTE: begin
                    case (opcode)
                        LUI, AUIPC, JAL, JALR, OP_IMM, OP: begin
                            pc_write  = 1'b1;
                            reg_write = 1'b1;
                            boundary  = 1'b1;
                        end
                        BRANCH: begin
                            pc_write = 1'b1;
                            boundary = 1'b1;
                        end
                        SYSTEM: begin
                            if (is_csr_f3(func3)) begin
                                pc_write  = 1'b1;
                                reg_write = 1'b1;
                                csr_write = 1'b1;
                                boundary  = 1'b1;
                            end else if (func3 == F3_PRIV) begin
                                pc_write = 1'b1;
                                boundary = 1'b1;
                            end else begin
                                illegal  = 1'b1;
                                take_exc = 1'b1;
                            end
                        end
                        LOAD: begin
                            mem_read2 = 1'b1;
                            ns        = bus.DMEM_RDY ? WRITE_BACK : MEM_WAIT;
                        end
                        STORE: begin
                            mem_write = 1'b1;
                            if (bus.DMEM_RDY) begin
                                pc_write = 1'b1;
                                boundary = 1'b1;
                            end else begin
                                ns = MEM_WAIT;
                            end
                        end
                        default: begin
                            illegal  = 1'b1;
                            take_exc = 1'b1;
                        end
                    endcase
                end

                MEM_WAIT: begin
                    if (opcode == STORE) begin
                        mem_write = 1'b1;
                        if (bus.DMEM_RDY) begin
                            pc_write = 1'b1;
                            boundary = 1'b1;
                        end else begin
                            ns = MEM_WAIT;
                        end
                    end else begin
                        mem_read2 = 1'b1;
                        ns        = bus.DMEM_RDY ? WRITE_BACK : MEM_WAIT;
                    end
                end

                WRITE_BACK: begin
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                    boundary  = 1'b1;
                end

                INTERRUPT: begin
                    pc_write  = 1'b1;
                    int_taken = 1'b1;
                    ns        = FETCH;
                end

                default: ns = FETCH;
            endcase

            // An exception wins over any pending interrupt and ignores MIE.
            if (take_exc) begin
                ns = INTERRUPT;
            end else if (boundary && pend_valid) begin
                take_irq = 1'b1;
                ns       = INTERRUPT;
            end
        end
    end

    assign bus.PC_WRITE  = pc_write;
    assign bus.REG_WRITE = reg_write;
    assign bus.MEM_WRITE = mem_write;
    assign bus.MEM_READ1 = mem_read1;
    assign bus.MEM_READ2 = mem_read2;
    assign bus.CSR_WRITE = csr_write;
    assign bus.INT_TAKEN = int_taken;
    assign bus.ILLEGAL   = illegal;
    assign bus.INT_CAUSE = int_cause_q;
    assign bus.INT_EXC   = int_exc_q;

endmodule

// File: tb/tb_cu_fsm_mc.sv
// Directed self-checking bench for cu_fsm_mc: instruction flows, wait states,
// interrupts, illegal trap and mid-operation reset.
module tb_cu_fsm_mc;

    // Strobe vector order: PC_WRITE REG_WRITE MEM_WRITE MEM_READ1 MEM_READ2 CSR_WRITE INT_TAKEN ILLEGAL
    localparam logic [7:0] S_NONE  = 8'b0000_0000;
    localparam logic [7:0] S_FETCH = 8'b0001_0000;
    localparam logic [7:0] S_ALU   = 8'b1100_0000;
    localparam logic [7:0] S_BR    = 8'b1000_0000;
    localparam logic [7:0] S_LD    = 8'b0000_1000;
    localparam logic [7:0] S_STW   = 8'b0010_0000;
    localparam logic [7:0] S_STD   = 8'b1010_0000;
    localparam logic [7:0] S_WB    = 8'b1100_0000;
    localparam logic [7:0] S_INT   = 8'b1000_0010;
    localparam logic [7:0] S_ILL   = 8'b0000_0001;
    localparam logic [7:0] S_CSR   = 8'b1100_0100;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cu_fsm_mc_if #(.NUM_IRQ(4)) bus ();

    cu_fsm_mc #(.NUM_IRQ(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    wire [7:0] stb = {bus.PC_WRITE, bus.REG_WRITE, bus.MEM_WRITE, bus.MEM_READ1,
                      bus.MEM_READ2, bus.CSR_WRITE, bus.INT_TAKEN, bus.ILLEGAL};

    task automatic chk_stb(input string tag, input logic [7:0] exp);
        checks++;
        assert (stb === exp) else begin
            errors++;
            $error("FAIL %s strobes=%b expected=%b", tag, stb, exp);
        end
    endtask

    task automatic chk_cause(input string tag, input logic [1:0] exp_cause, input logic exp_exc);
        checks++;
        assert ({bus.INT_CAUSE, bus.INT_EXC} === {exp_cause, exp_exc}) else begin
            errors++;
            $error("FAIL %s cause=%0d exc=%b expected cause=%0d exc=%b",
                   tag, bus.INT_CAUSE, bus.INT_EXC, exp_cause, exp_exc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the current cycle's strobes mid-cycle, then advance one clock.
    task automatic step(input string tag, input logic [7:0] exp);
        #1;
        chk_stb(tag, exp);
        tick();
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] instr);
        bus.DIN      = instr;
        bus.IMEM_RDY = 1'b1;
        step(tag, S_FETCH);
        bus.IMEM_RDY = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.DIN      = 32'h0;
        bus.IMEM_RDY = 1'b0;
        bus.DMEM_RDY = 1'b0;
        bus.IRQ      = 4'b0000;
        bus.IRQ_MASK = 4'b0000;
        bus.MIE      = 1'b0;

        #1;
        chk_stb("reset_strobes", S_NONE);
        chk_cause("reset_cause", 2'd0, 1'b0);
        tick();
        rst = 1'b0;

        // FETCH holds while IMEM_RDY is low
        step("fetch_idle0", S_FETCH);
        step("fetch_idle1", S_FETCH);

        // ADDI
        do_fetch("addi_fetch", 32'h0010_0093);
        step("addi_exec", S_ALU);
        step("addi_next_fetch", S_FETCH);

        // LW with three low DMEM_RDY cycles
        do_fetch("lw_fetch", 32'h0000_a103);
        bus.DMEM_RDY = 1'b0;
        step("lw_exec", S_LD);
        step("lw_wait1", S_LD);
        step("lw_wait2", S_LD);
        bus.DMEM_RDY = 1'b1;
        step("lw_wait_rdy", S_LD);
        bus.DMEM_RDY = 1'b0;
        step("lw_wb", S_WB);
        step("lw_next_fetch", S_FETCH);

        // SW, memory ready immediately
        do_fetch("sw0_fetch", 32'h0020_a023);
        bus.DMEM_RDY = 1'b1;
        step("sw0_exec", S_STD);
        bus.DMEM_RDY = 1'b0;
        step("sw0_next_fetch", S_FETCH);

        // SW with two wait cycles
        do_fetch("sw2_fetch", 32'h0020_a023);
        step("sw2_exec", S_STW);
        step("sw2_wait1", S_STW);
        bus.DMEM_RDY = 1'b1;
        step("sw2_wait_rdy", S_STD);
        bus.DMEM_RDY = 1'b0;
        step("sw2_next_fetch", S_FETCH);

        // ADD with IRQ 1011 masked by 1110: pending 1010, line 1 wins
        bus.MIE      = 1'b1;
        bus.IRQ_MASK = 4'b1110;
        bus.IRQ      = 4'b1011;
        do_fetch("add_fetch_irq_ignored", 32'h0020_81b3);
        #1;
        chk_cause("add_exec_cause_unlatched", 2'd0, 1'b0);
        step("add_exec", S_ALU);
        #1;
        chk_cause("add_int_cause", 2'd1, 1'b0);
        bus.IRQ = 4'b0000;
        step("add_int", S_INT);
        step("add_after_int_fetch", S_FETCH);
        chk_cause("add_cause_hold", 2'd1, 1'b0);
        bus.MIE = 1'b0;

        // Illegal opcode with MIE=0
        do_fetch("ill_fetch", 32'h0000_007f);
        step("ill_exec", S_ILL);
        #1;
        chk_cause("ill_cause", 2'd0, 1'b1);
        step("ill_int", S_INT);
        step("ill_next_fetch", S_FETCH);

        // CSRRW, cause registers hold
        do_fetch("csr_fetch", 32'h3057_1073);
        step("csr_exec", S_CSR);
        #1;
        chk_cause("csr_cause_hold", 2'd0, 1'b1);
        step("csr_next_fetch", S_FETCH);

        // BEQ with IRQ 1100 fully enabled: line 2 wins
        bus.MIE      = 1'b1;
        bus.IRQ_MASK = 4'b1111;
        bus.IRQ      = 4'b1100;
        do_fetch("beq_fetch", 32'h0020_8463);
        step("beq_exec", S_BR);
        #1;
        chk_cause("beq_int_cause", 2'd2, 1'b0);
        bus.IRQ = 4'b0000;
        step("beq_int", S_INT);
        step("beq_next_fetch", S_FETCH);
        bus.MIE = 1'b0;

        // Reset asserted during a load's MEM_WAIT
        do_fetch("rst_lw_fetch", 32'h0000_a103);
        step("rst_lw_exec", S_LD);
        #1;
        chk_stb("rst_lw_wait", S_LD);
        rst = 1'b1;
        #1;
        chk_stb("rst_strobes_drop", S_NONE);
        chk_cause("rst_cause_clear", 2'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_stb("rst_release_fetch", S_FETCH);
        chk_cause("rst_release_cause", 2'd0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cu_fsm_mc.md
Name: cu_fsm_mc

Overview:
- Multicycle control FSM for the OTTER RV32I core; next generation of the fixed-timing control unit.
- Adds ready/valid wait-state handshakes for instruction and data memory.
- Adds NUM_IRQ prioritised, maskable interrupt lines with a registered cause, plus illegal-opcode trapping.
- Drives PC, register file, memory, CSR and trap strobes from the fetched instruction word.

Parameters:
- NUM_IRQ, 4, number of interrupt request lines; legal range 2..16.
- IRQ_W, $clog2(NUM_IRQ), width of INT_CAUSE; derived, never overridden.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- DIN  in  32  instruction word; valid from the EXECUTE cycle onward.
- IMEM_RDY  in  1  instruction memory done; completes fetch.
- DMEM_RDY  in  1  data memory done; completes load or store.
- IRQ  in  NUM_IRQ  level-sensitive interrupt requests.
- IRQ_MASK  in  NUM_IRQ  per-line enable (CSR mie).
- MIE  in  1  global interrupt enable (mstatus.MIE).
- PC_WRITE, REG_WRITE, MEM_WRITE, MEM_READ1, MEM_READ2, CSR_WRITE, INT_TAKEN  out  1 each  combinational strobes.
- ILLEGAL  out  1  one-cycle pulse on an undecodable opcode.
- INT_CAUSE  out  IRQ_W  registered index of the interrupt being taken.
- INT_EXC  out  1  registered; 1 = trap is an exception, 0 = interrupt.

Behaviour:
- States: FETCH, EXECUTE, MEM_WAIT, WRITE_BACK, INTERRUPT.
- Reset: PS=FETCH, INT_CAUSE=0, INT_EXC=0. All strobes are 0 while RST is high. RST mid-operation aborts any wait and returns to FETCH.
- Strobes not listed for a state are 0.
- pending = IRQ & IRQ_MASK & {NUM_IRQ{MIE}}.
- Priority: lowest index wins.
- Boundary: the cycle an instruction completes.
  - pending!=0 at the boundary: NS=INTERRUPT; latch INT_CAUSE = winning index, INT_EXC=0.
  - Otherwise NS=FETCH.
- FETCH:
  - MEM_READ1=1.
  - IMEM_RDY=1: NS=EXECUTE. Else stay in FETCH.
  - Interrupts are never taken from FETCH.
- EXECUTE, decode on DIN[6:0] and DIN[14:12]:
  - LUI/AUIPC/JAL/JALR/OP_IMM/OP: PC_WRITE=1, REG_WRITE=1; boundary.
  - BRANCH: PC_WRITE=1; boundary.
  - SYSTEM, func3 001/010/011: PC_WRITE=1, REG_WRITE=1, CSR_WRITE=1; boundary.
  - SYSTEM, func3 000: PC_WRITE=1; boundary.
  - SYSTEM, other func3: treated as illegal.
  - LOAD: MEM_READ2=1. DMEM_RDY=1: NS=WRITE_BACK. Else NS=MEM_WAIT.
  - STORE: MEM_WRITE=1. DMEM_RDY=1: PC_WRITE=1; boundary. Else NS=MEM_WAIT.
  - Any other opcode: ILLEGAL=1, PC_WRITE=0; NS=INTERRUPT; latch INT_EXC=1, INT_CAUSE=0. An exception ignores MIE and overrides any pending interrupt.
- MEM_WAIT:
  - Holds MEM_READ2 (load) or MEM_WRITE (store), selected by DIN opcode.
  - On DMEM_RDY: a load goes to WRITE_BACK; a store asserts PC_WRITE=1; boundary.
- WRITE_BACK: PC_WRITE=1, REG_WRITE=1; boundary.
- INTERRUPT: PC_WRITE=1, INT_TAKEN=1; NS=FETCH. INT_CAUSE/INT_EXC hold until the next latch.
- Interrupted instruction always retires its own PC_WRITE first. INTERRUPT then redirects the PC to mtvec.
- IRQ asserted during FETCH or MEM_WAIT is sampled only at the next boundary. IRQ deasserted before the boundary is not taken.
- Default/unreachable PS: all strobes 0, NS=FETCH.

Decomposition:
- Package otter_pkg:
  - opcode_t enum: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, SYSTEM 1110011.
  - cu_state_t enum.
  - func3 constants for CSR ops.
- Sub-module irq_prio_enc (parameter N): pending vector → valid flag + index; purely combinational.
- FSM, cause registers and decode stay in cu_fsm_mc.

Test Plan:
- ADDI 0x00100093, IMEM_RDY=1, IRQ=0: FETCH→EXECUTE→FETCH. One PC_WRITE+REG_WRITE pulse in EXECUTE.
- LW 0x0000a103, DMEM_RDY low 3 cycles: MEM_READ2 high for 4 cycles, then WRITE_BACK. PC_WRITE=REG_WRITE=1 exactly once.
- SW 0x0020a023, DMEM_RDY immediate, then with 2 wait cycles: MEM_WRITE held 1 and 3 cycles respectively. PC_WRITE only on the RDY cycle.
- MIE=1, IRQ_MASK=4'b1110, IRQ=4'b1011 during ADD: ADD retires, INTERRUPT follows with INT_CAUSE=1, INT_EXC=0, INT_TAKEN=1 for one cycle.
- Opcode 7'b1111111 with MIE=0: ILLEGAL pulse, no PC_WRITE in EXECUTE; INTERRUPT with INT_EXC=1, INT_CAUSE=0.
- Assert RST during a MEM_WAIT on a load: strobes drop to 0 immediately. After release PS=FETCH, MEM_READ1=1, INT_CAUSE=0.
